snake_body_sequencer: RTL

Owns the snake's body-segment store: a circular buffer of segment coordinates on a 10-pixel grid. Each move tick from the game controller advances the head one grid step, checks wall and self-collision, then commits the move, growing the body if requested. The VGA renderer reads segments through a shared read port, arbitrated against the internal collision scan.

---
 rtl/snake_body_sequencer_if.sv | 19 +
 rtl/snake_body_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/snake_body_sequencer_if.sv
// snake_body_sequencer_if: renderer read port into the snake segment store.
// master = renderer, slave = sequencer.
interface snake_body_sequencer_if;
  logic        rd_req;
  logic [3:0]  rd_idx;
  logic        rd_ack;
  logic [10:0] rd_x;
  logic [10:0] rd_y;

  modport master (
    output rd_req, rd_idx,
    input  rd_ack, rd_x, rd_y
  );

  modport slave (
    input  rd_req, rd_idx,
    output rd_ack, rd_x, rd_y
  );
endinterface

// File: rtl/snake_body_sequencer.sv
// snake_body_sequencer: circular segment store, move FSM, collision scan, read port.
// Define SNAKE_WRAP_EN to wrap the head at field edges instead of dying.
module snake_body_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int STEP    = 10,
  parameter int X_MAX   = 630,
  parameter int Y_MAX   = 470,
  parameter int INIT_X  = 310,
  parameter int INIT_Y  = 230
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        move_tick,
  input  logic        restart,
  input  logic [1:0]  dir,
  input  logic        grow,
  output logic [10:0] head_x,
  output logic [10:0] head_y,
  output logic [4:0]  len,
  output logic [1:0]  cur_dir,
  output logic        dead,
  output logic        busy,
  snake_body_sequencer_if.slave rd
);
  localparam int AW = $clog2(MAX_LEN);
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam logic [21:0] INIT_SEG = {11'(INIT_X), 11'(INIT_Y)};

  typedef enum logic [2:0] {IDLE, CALC, SCAN, COMMIT, DEAD} state_t;

  state_t        state;
  state_t        state_n;
  logic [21:0]   mem [MAX_LEN];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] scan_i;
  logic [1:0]    mv_dir;
  logic          mv_grow;
  logic [10:0]   nx;
  logic [10:0]   ny;
  logic          wall;
  logic          hit;
  logic [4:0]    scan_cnt;
  logic [21:0]   scan_seg;
  logic [21:0]   rd_seg;

  assign busy     = (state != IDLE) && (state != DEAD);
  assign scan_seg = mem[head_ptr - scan_i];
  assign hit      = (scan_seg == {nx, ny});
  assign rd_seg   = mem[head_ptr - AW'(rd.rd_idx)];

  // Tail is only a hazard when it stays put, i.e. on a growing move.
  assign scan_cnt = mv_grow ? len - 5'd1 :
                    (len > 5'd1 ? len - 5'd2 : 5'd0);

  // Wrapped coordinates double as the wrap-mode result.
  always_comb begin
    nx   = head_x;
    ny   = head_y;
    wall = 1'b0;
    unique case (mv_dir)
      2'd0:
        if (head_y < 11'(STEP)) begin
          wall = 1'b1;
          ny   = 11'(Y_MAX);
        end else ny = head_y - 11'(STEP);
      2'd1:
        if (head_x > 11'(X_MAX - STEP)) begin
          wall = 1'b1;
          nx   = '0;
        end else nx = head_x + 11'(STEP);
      2'd2:
        if (head_y > 11'(Y_MAX - STEP)) begin
          wall = 1'b1;
          ny   = '0;
        end else ny = head_y + 11'(STEP);
      2'd3:
        if (head_x < 11'(STEP)) begin
          wall = 1'b1;
          nx   = 11'(X_MAX);
        end else nx = head_x - 11'(STEP);
    endcase
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (move_tick) state_n = CALC;
      CALC:
        if (wall && !WRAP)         state_n = DEAD;
        else if (scan_cnt == 5'd0) state_n = COMMIT;
        else                       state_n = SCAN;
      SCAN:
        if (hit)                          state_n = DEAD;
        else if (5'(scan_i) == scan_cnt)  state_n = COMMIT;
      COMMIT: state_n = IDLE;
      DEAD:   state_n = DEAD;
      default: state_n = IDLE;
    endcase
    if (restart) state_n = IDLE;
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LEN; k++) mem[k] <= '0;
      mem[0]   <= INIT_SEG;
      head_ptr <= '0;
      scan_i   <= AW'(1);
      head_x   <= 11'(INIT_X);
      head_y   <= 11'(INIT_Y);
      len      <= 5'd1;
      cur_dir  <= 2'd1;
      dead     <= 1'b0;
      mv_dir   <= 2'd1;
      mv_grow  <= 1'b0;
    end else if (restart) begin
      mem[0]   <= INIT_SEG;
      head_ptr <= '0;
      head_x   <= 11'(INIT_X);
      head_y   <= 11'(INIT_Y);
      len      <= 5'd1;
      cur_dir  <= 2'd1;
      dead     <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (move_tick) begin
            mv_dir  <= (dir == (cur_dir ^ 2'd2)) ? cur_dir : dir;
            mv_grow <= grow;
          end
        CALC: begin
          scan_i <= AW'(1);
          if (state_n == DEAD) dead <= 1'b1;
        end
        SCAN: begin
          scan_i <= scan_i + AW'(1);
          if (state_n == DEAD) dead <= 1'b1;
        end
        COMMIT: begin
          head_ptr                <= head_ptr + AW'(1);
          mem[head_ptr + AW'(1)]  <= {nx, ny};
          head_x                  <= nx;
          head_y                  <= ny;
          cur_dir                 <= mv_dir;
          if (mv_grow && len < 5'(MAX_LEN)) len <= len + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // The scan engine owns the buffer in SCAN; the ack guard stops a
  // still-held request from being served twice.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      rd.rd_ack <= 1'b0;
      rd.rd_x   <= '0;
      rd.rd_y   <= '0;
    end else begin
      rd.rd_ack <= 1'b0;
      if (rd.rd_req && !rd.rd_ack && state != SCAN) begin
        rd.rd_ack <= 1'b1;
        if ({1'b0, rd.rd_idx} >= len) begin
          rd.rd_x <= 11'h7FF;
          rd.rd_y <= 11'h7FF;
        end else begin
          rd.rd_x <= rd_seg[21:11];
          rd.rd_y <= rd_seg[10:0];
        end
      end
    end
  end
endmodule
